// File: rtl/fu_writeback_arbiter.sv
// Write-back arbiter: shares the CDB and the ROB write port among NUM_FU functional units.
// Each channel has its own round-robin grant, and the winner's payload is registered for broadcast.
module fu_writeback_arbiter #(
  parameter int NUM_FU = 4,
  parameter int ID_W   = 4,
  parameter int DATA_W = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,

  input  logic [NUM_FU-1:0]                  fu_cdb_req,
  input  logic [NUM_FU-1:0][ID_W-1:0]        fu_cdb_id,
  input  logic [NUM_FU-1:0][DATA_W-1:0]      fu_cdb_val,
  output logic [NUM_FU-1:0]                  fu_cdb_grant,
  output logic                               cdb_valid,
  output logic [ID_W-1:0]                    cdb_id,
  output logic [DATA_W-1:0]                  cdb_val,

  input  logic [NUM_FU-1:0]                  fu_rob_req,
  input  logic [NUM_FU-1:0][ID_W-1:0]        fu_rob_robid,
  input  logic [NUM_FU-1:0][DATA_W-1:0]      fu_rob_flags,
  input  logic [NUM_FU-1:0][DATA_W-1:0]      fu_rob_wbs,
  input  logic [NUM_FU-1:0][DATA_W-1:0]      fu_rob_value,
  input  logic                               rob_ready,
  output logic [NUM_FU-1:0]                  fu_rob_grant,
  output logic                               rob_valid,
  output logic [ID_W-1:0]                    rob_robid,
  output logic [DATA_W-1:0]                  rob_flags,
  output logic [DATA_W-1:0]                  rob_wbs,
  output logic [DATA_W-1:0]                  rob_value
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_FU - 1);

  // Returns {hit, index}. The scan runs from lowest to highest priority, so the final
  // hit is the requester closest after 'last'.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_FU-1:0] req,
                                             input logic [IDX_W-1:0]  last);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] pos;
    res = '0;
    for (int k = NUM_FU; k >= 1; k--) begin
      pos = IDX_W'((int'(last) + k) % NUM_FU);
      if (req[pos]) res = {1'b1, pos};
    end
    return res;
  endfunction

  logic [IDX_W-1:0] cdb_last;
  logic [IDX_W:0]   cdb_pick;
  logic [IDX_W-1:0] cdb_win;
  logic             cdb_fire;

  logic [IDX_W-1:0] rob_last;
  logic [IDX_W:0]   rob_pick;
  logic [IDX_W-1:0] rob_win;
  logic             rob_fire;

  assign cdb_pick = rr_pick(fu_cdb_req, cdb_last);
  assign cdb_win  = cdb_pick[IDX_W-1:0];
  assign cdb_fire = cdb_pick[IDX_W] && !flush && !rst;

  assign rob_pick = rr_pick(fu_rob_req, rob_last);
  assign rob_win  = rob_pick[IDX_W-1:0];
  assign rob_fire = rob_pick[IDX_W] && rob_ready && !flush && !rst;

  assign fu_cdb_grant = cdb_fire ? (NUM_FU'(1) << cdb_win) : '0;
  assign fu_rob_grant = rob_fire ? (NUM_FU'(1) << rob_win) : '0;

  // The payload registers keep their last value when nothing wins, so only valid toggles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_last  <= LAST_RST;
      cdb_valid <= 1'b0;
      cdb_id    <= '0;
      cdb_val   <= '0;
    end else begin
      cdb_valid <= cdb_fire;
      if (cdb_fire) begin
        cdb_last <= cdb_win;
        cdb_id   <= fu_cdb_id[cdb_win];
        cdb_val  <= fu_cdb_val[cdb_win];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rob_last  <= LAST_RST;
      rob_valid <= 1'b0;
      rob_robid <= '0;
      rob_flags <= '0;
      rob_wbs   <= '0;
      rob_value <= '0;
    end else begin
      rob_valid <= rob_fire;
      if (rob_fire) begin
        rob_last  <= rob_win;
        rob_robid <= fu_rob_robid[rob_win];
        rob_flags <= fu_rob_flags[rob_win];
        rob_wbs   <= fu_rob_wbs[rob_win];
        rob_value <= fu_rob_value[rob_win];
      end
    end
  end

endmodule

// File: tb/tb_fu_writeback_arbiter.sv
// Bench for fu_writeback_arbiter: directed scenarios plus randomized traffic checked against
// a round-robin reference model of both channels.
module tb_fu_writeback_arbiter;
  localparam int NUM_FU = 4;
  localparam int ID_W   = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic rob_ready = 1'b1;

  logic [NUM_FU-1:0]             fu_cdb_req = '0;
  logic [NUM_FU-1:0][ID_W-1:0]   fu_cdb_id  = '0;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_cdb_val = '0;
  logic [NUM_FU-1:0]             fu_cdb_grant;
  logic                          cdb_valid;
  logic [ID_W-1:0]               cdb_id;
  logic [DATA_W-1:0]             cdb_val;

  logic [NUM_FU-1:0]             fu_rob_req   = '0;
  logic [NUM_FU-1:0][ID_W-1:0]   fu_rob_robid = '0;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_rob_flags = '0;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_rob_wbs   = '0;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_rob_value = '0;
  logic [NUM_FU-1:0]             fu_rob_grant;
  logic                          rob_valid;
  logic [ID_W-1:0]               rob_robid;
  logic [DATA_W-1:0]             rob_flags;
  logic [DATA_W-1:0]             rob_wbs;
  logic [DATA_W-1:0]             rob_value;

  int checks = 0;
  int errors = 0;

  // Reference model state: most recent winner per channel and the expected output registers.
  int                m_cdb_last;
  int                m_rob_last;
  logic              e_cdb_valid;
  logic [ID_W-1:0]   e_cdb_id;
  logic [DATA_W-1:0] e_cdb_val;
  logic              e_rob_valid;
  logic [ID_W-1:0]   e_rob_robid;
  logic [DATA_W-1:0] e_rob_flags;
  logic [DATA_W-1:0] e_rob_wbs;
  logic [DATA_W-1:0] e_rob_value;

  fu_writeback_arbiter #(.NUM_FU(NUM_FU), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_cdb_req(fu_cdb_req), .fu_cdb_id(fu_cdb_id), .fu_cdb_val(fu_cdb_val),
    .fu_cdb_grant(fu_cdb_grant), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
    .fu_rob_req(fu_rob_req), .fu_rob_robid(fu_rob_robid), .fu_rob_flags(fu_rob_flags),
    .fu_rob_wbs(fu_rob_wbs), .fu_rob_value(fu_rob_value), .rob_ready(rob_ready),
    .fu_rob_grant(fu_rob_grant), .rob_valid(rob_valid), .rob_robid(rob_robid),
    .rob_flags(rob_flags), .rob_wbs(rob_wbs), .rob_value(rob_value)
  );

  always #5 clk = ~clk;

  // First requester after 'last' in circular order, or -1 if nobody requests.
  function automatic int pick(input logic [NUM_FU-1:0] req, input int last);
    for (int k = 1; k <= NUM_FU; k++) begin
      if (req[(last + k) % NUM_FU]) return (last + k) % NUM_FU;
    end
    return -1;
  endfunction

  function automatic logic [NUM_FU-1:0] onehot(input int w);
    logic [NUM_FU-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_cdb_last  = NUM_FU - 1;
    m_rob_last  = NUM_FU - 1;
    e_cdb_valid = 1'b0; e_cdb_id = '0; e_cdb_val = '0;
    e_rob_valid = 1'b0; e_rob_robid = '0; e_rob_flags = '0; e_rob_wbs = '0; e_rob_value = '0;
  endtask

  task automatic predict(output int cw, output int rw);
    cw = (rst || flush) ? -1 : pick(fu_cdb_req, m_cdb_last);
    rw = (rst || flush || !rob_ready) ? -1 : pick(fu_rob_req, m_rob_last);
  endtask

  // Clock the design and move the model's expected registers across the same edge.
  task automatic advance(input int cw, input int rw);
    @(posedge clk);
    if (cw >= 0) begin
      m_cdb_last = cw; e_cdb_valid = 1'b1;
      e_cdb_id = fu_cdb_id[cw]; e_cdb_val = fu_cdb_val[cw];
    end else e_cdb_valid = 1'b0;
    if (rw >= 0) begin
      m_rob_last = rw; e_rob_valid = 1'b1;
      e_rob_robid = fu_rob_robid[rw]; e_rob_flags = fu_rob_flags[rw];
      e_rob_wbs = fu_rob_wbs[rw]; e_rob_value = fu_rob_value[rw];
    end else e_rob_valid = 1'b0;
    #1;
  endtask

  // FU side of the handshake: a granted FU drops its request or presents fresh data.
  task automatic fu_retire(input int cw, input int rw, input bit renew);
    if (cw >= 0) begin
      if (renew && $urandom_range(0, 1) == 1) begin
        fu_cdb_id[cw] = ID_W'($urandom); fu_cdb_val[cw] = DATA_W'($urandom);
      end else fu_cdb_req[cw] = 1'b0;
    end
    if (rw >= 0) begin
      if (renew && $urandom_range(0, 1) == 1) begin
        fu_rob_robid[rw] = ID_W'($urandom); fu_rob_flags[rw] = DATA_W'($urandom);
        fu_rob_wbs[rw] = DATA_W'($urandom); fu_rob_value[rw] = DATA_W'($urandom);
      end else fu_rob_req[rw] = 1'b0;
    end
  endtask

  task automatic test_reset();
    fu_cdb_req = '1; fu_rob_req = '1;
    #3;
    checks++;
    if (fu_cdb_grant !== '0 || fu_rob_grant !== '0) begin
      errors++; $display("[TB] FAIL reset_grants: got cdb=%b rob=%b expected 0", fu_cdb_grant, fu_rob_grant);
    end
    checks++;
    if ({cdb_valid, cdb_id, cdb_val} !== '0) begin
      errors++; $display("[TB] FAIL reset_cdb_out: got %b/%h/%h expected all 0", cdb_valid, cdb_id, cdb_val);
    end
    checks++;
    if ({rob_valid, rob_robid, rob_flags, rob_wbs, rob_value} !== '0) begin
      errors++; $display("[TB] FAIL reset_rob_out: got valid=%b id=%h expected all 0", rob_valid, rob_robid);
    end
    fu_cdb_req = '0; fu_rob_req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_cdb_round_robin();
    int cw, rw;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_cdb_req[i] = 1'b1; fu_cdb_id[i] = ID_W'(i + 1); fu_cdb_val[i] = DATA_W'((i + 1) * 16);
    end
    for (int c = 0; c < NUM_FU + 1; c++) begin
      #1; predict(cw, rw);
      checks++;
      if (fu_cdb_grant !== onehot(cw)) begin
        errors++; $display("[TB] FAIL rr_grant c%0d: got %b expected %b", c, fu_cdb_grant, onehot(cw));
      end
      advance(cw, rw);
      checks++;
      if ({cdb_valid, cdb_id, cdb_val} !== {e_cdb_valid, e_cdb_id, e_cdb_val}) begin
        errors++; $display("[TB] FAIL rr_cdb_out c%0d: got %b/%h/%h expected %b/%h/%h",
                           c, cdb_valid, cdb_id, cdb_val, e_cdb_valid, e_cdb_id, e_cdb_val);
      end
      if (c < NUM_FU) begin
        checks++;
        if (cdb_valid !== 1'b1 || cdb_id !== ID_W'(c + 1) || cdb_val !== DATA_W'((c + 1) * 16)) begin
          errors++; $display("[TB] FAIL rr_sequence c%0d: got %b/%h/%h expected 1/%h/%h",
                             c, cdb_valid, cdb_id, cdb_val, c + 1, (c + 1) * 16);
        end
      end
      fu_retire(cw, rw, 1'b0);
    end
  endtask

  task automatic test_single_requester();
    int cw, rw;
    for (int c = 0; c < 3; c++) begin
      fu_cdb_req[3] = 1'b1; fu_cdb_id[3] = ID_W'(7 + c); fu_cdb_val[3] = DATA_W'(8'hA0 + c);
      #1; predict(cw, rw);
      checks++;
      if (fu_cdb_grant !== 4'b1000) begin
        errors++; $display("[TB] FAIL single_grant c%0d: got %b expected 1000", c, fu_cdb_grant);
      end
      advance(cw, rw);
      checks++;
      if ({cdb_valid, cdb_id, cdb_val} !== {1'b1, ID_W'(7 + c), DATA_W'(8'hA0 + c)}) begin
        errors++; $display("[TB] FAIL single_cdb_out c%0d: got %b/%h/%h expected 1/%h/%h",
                           c, cdb_valid, cdb_id, cdb_val, 7 + c, 8'hA0 + c);
      end
    end
    fu_cdb_req = '0;
  endtask

  task automatic test_wrap();
    int cw, rw;
    logic [NUM_FU-1:0] want [3];
    want[0] = 4'b0010; want[1] = 4'b1000; want[2] = 4'b0001;
    fu_cdb_req[1] = 1'b1; fu_cdb_id[1] = 4'h5; fu_cdb_val[1] = 8'h55;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        fu_cdb_req[0] = 1'b1; fu_cdb_id[0] = 4'hC; fu_cdb_val[0] = 8'hC0;
        fu_cdb_req[3] = 1'b1; fu_cdb_id[3] = 4'hD; fu_cdb_val[3] = 8'hD3;
      end
      #1; predict(cw, rw);
      checks++;
      if (fu_cdb_grant !== want[c]) begin
        errors++; $display("[TB] FAIL wrap_grant c%0d: got %b expected %b", c, fu_cdb_grant, want[c]);
      end
      advance(cw, rw);
      checks++;
      if ({cdb_valid, cdb_id, cdb_val} !== {e_cdb_valid, e_cdb_id, e_cdb_val}) begin
        errors++; $display("[TB] FAIL wrap_cdb_out c%0d: got %b/%h/%h expected %b/%h/%h",
                           c, cdb_valid, cdb_id, cdb_val, e_cdb_valid, e_cdb_id, e_cdb_val);
      end
      fu_retire(cw, rw, 1'b0);
    end
  endtask

  task automatic test_rob_stall();
    int cw, rw;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_cdb_req[i] = 1'b1; fu_cdb_id[i] = ID_W'(i + 9); fu_cdb_val[i] = DATA_W'($urandom);
      fu_rob_req[i] = 1'b1; fu_rob_robid[i] = ID_W'(i + 8); fu_rob_flags[i] = DATA_W'($urandom);
      fu_rob_wbs[i] = DATA_W'($urandom); fu_rob_value[i] = DATA_W'($urandom);
    end
    for (int c = 0; c < 7; c++) begin
      rob_ready = (c >= 2);
      #1; predict(cw, rw);
      checks++;
      if (fu_cdb_grant !== onehot(cw) || fu_rob_grant !== onehot(rw)) begin
        errors++; $display("[TB] FAIL stall_grant c%0d: got cdb=%b rob=%b expected cdb=%b rob=%b",
                           c, fu_cdb_grant, fu_rob_grant, onehot(cw), onehot(rw));
      end
      if (c == 2) begin
        checks++;
        if (fu_rob_grant !== 4'b0001) begin
          errors++; $display("[TB] FAIL stall_resume: got %b expected 0001", fu_rob_grant);
        end
      end
      advance(cw, rw);
      checks++;
      if ({cdb_valid, cdb_id, cdb_val} !== {e_cdb_valid, e_cdb_id, e_cdb_val}) begin
        errors++; $display("[TB] FAIL stall_cdb_out c%0d: got %b/%h/%h expected %b/%h/%h",
                           c, cdb_valid, cdb_id, cdb_val, e_cdb_valid, e_cdb_id, e_cdb_val);
      end
      checks++;
      if ({rob_valid, rob_robid, rob_flags, rob_wbs, rob_value} !==
          {e_rob_valid, e_rob_robid, e_rob_flags, e_rob_wbs, e_rob_value}) begin
        errors++; $display("[TB] FAIL stall_rob_out c%0d: got %b/%h/%h/%h/%h expected %b/%h/%h/%h/%h",
                           c, rob_valid, rob_robid, rob_flags, rob_wbs, rob_value,
                           e_rob_valid, e_rob_robid, e_rob_flags, e_rob_wbs, e_rob_value);
      end
      fu_retire(cw, rw, 1'b0);
    end
    rob_ready = 1'b1;
  endtask

  task automatic test_flush();
    int cw, rw;
    fu_cdb_req[2] = 1'b1; fu_cdb_id[2] = 4'h2; fu_cdb_val[2] = 8'h22;
    fu_rob_req[2] = 1'b1; fu_rob_robid[2] = 4'h6; fu_rob_flags[2] = 8'h01;
    fu_rob_wbs[2] = 8'h02; fu_rob_value[2] = 8'h66;
    for (int c = 0; c < 2; c++) begin
      flush = (c == 0);
      #1; predict(cw, rw);
      checks++;
      if (fu_cdb_grant !== onehot(cw) || fu_rob_grant !== onehot(rw)) begin
        errors++; $display("[TB] FAIL flush_grant c%0d: got cdb=%b rob=%b expected cdb=%b rob=%b",
                           c, fu_cdb_grant, fu_rob_grant, onehot(cw), onehot(rw));
      end
      advance(cw, rw);
      checks++;
      if (cdb_valid !== (c == 1) || rob_valid !== (c == 1)) begin
        errors++; $display("[TB] FAIL flush_valid c%0d: got cdb=%b rob=%b expected %0d",
                           c, cdb_valid, rob_valid, c);
      end
      checks++;
      if ({rob_valid, rob_robid, rob_value, cdb_id, cdb_val} !==
          {e_rob_valid, e_rob_robid, e_rob_value, e_cdb_id, e_cdb_val}) begin
        errors++; $display("[TB] FAIL flush_payload c%0d: got rob=%h/%h cdb=%h/%h expected rob=%h/%h cdb=%h/%h",
                           c, rob_robid, rob_value, cdb_id, cdb_val, e_rob_robid, e_rob_value, e_cdb_id, e_cdb_val);
      end
      fu_retire(cw, rw, 1'b0);
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    int cw, rw;
    fu_cdb_req[1] = 1'b1; fu_cdb_id[1] = 4'h3; fu_cdb_val[1] = 8'h31;
    fu_rob_req[1] = 1'b1; fu_rob_robid[1] = 4'h3; fu_rob_value[1] = 8'h32;
    #1; predict(cw, rw);
    advance(cw, rw);
    checks++;
    if (cdb_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL areset_pre: got cdb_valid=%b expected 1", cdb_valid);
    end
    fu_retire(cw, rw, 1'b0);
    fu_cdb_req[0] = 1'b1; fu_cdb_id[0] = 4'hE; fu_cdb_val[0] = 8'hE0;
    fu_cdb_req[1] = 1'b1; fu_cdb_id[1] = 4'hF; fu_cdb_val[1] = 8'hF1;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || rob_valid !== 1'b0 || fu_cdb_grant !== '0 || fu_rob_grant !== '0) begin
      errors++; $display("[TB] FAIL areset_clear: got cdb_valid=%b rob_valid=%b grant=%b expected 0/0/0",
                         cdb_valid, rob_valid, fu_cdb_grant);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1; predict(cw, rw);
    checks++;
    if (fu_cdb_grant !== 4'b0001) begin
      errors++; $display("[TB] FAIL areset_first: got %b expected 0001", fu_cdb_grant);
    end
    advance(cw, rw);
    checks++;
    if ({cdb_valid, cdb_id, cdb_val} !== {1'b1, 4'hE, 8'hE0}) begin
      errors++; $display("[TB] FAIL areset_cdb_out: got %b/%h/%h expected 1/e/e0", cdb_valid, cdb_id, cdb_val);
    end
    fu_retire(cw, rw, 1'b0);
    #1; predict(cw, rw);
    advance(cw, rw);
    fu_retire(cw, rw, 1'b0);
  endtask

  task automatic test_random();
    int cw, rw;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!fu_cdb_req[i] && $urandom_range(0, 2) == 0) begin
          fu_cdb_req[i] = 1'b1; fu_cdb_id[i] = ID_W'($urandom); fu_cdb_val[i] = DATA_W'($urandom);
        end
        if (!fu_rob_req[i] && $urandom_range(0, 2) == 0) begin
          fu_rob_req[i] = 1'b1; fu_rob_robid[i] = ID_W'($urandom); fu_rob_flags[i] = DATA_W'($urandom);
          fu_rob_wbs[i] = DATA_W'($urandom); fu_rob_value[i] = DATA_W'($urandom);
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      rob_ready = ($urandom_range(0, 3) != 0);
      #1; predict(cw, rw);
      checks++;
      if (fu_cdb_grant !== onehot(cw) || fu_rob_grant !== onehot(rw)) begin
        errors++; $display("[TB] FAIL rand_grant c%0d: got cdb=%b rob=%b expected cdb=%b rob=%b",
                           c, fu_cdb_grant, fu_rob_grant, onehot(cw), onehot(rw));
      end
      advance(cw, rw);
      checks++;
      if ({cdb_valid, cdb_id, cdb_val} !== {e_cdb_valid, e_cdb_id, e_cdb_val}) begin
        errors++; $display("[TB] FAIL rand_cdb_out c%0d: got %b/%h/%h expected %b/%h/%h",
                           c, cdb_valid, cdb_id, cdb_val, e_cdb_valid, e_cdb_id, e_cdb_val);
      end
      checks++;
      if ({rob_valid, rob_robid, rob_flags, rob_wbs, rob_value} !==
          {e_rob_valid, e_rob_robid, e_rob_flags, e_rob_wbs, e_rob_value}) begin
        errors++; $display("[TB] FAIL rand_rob_out c%0d: got %b/%h/%h/%h/%h expected %b/%h/%h/%h/%h",
                           c, rob_valid, rob_robid, rob_flags, rob_wbs, rob_value,
                           e_rob_valid, e_rob_robid, e_rob_flags, e_rob_wbs, e_rob_value);
      end
      fu_retire(cw, rw, 1'b1);
    end
    flush = 1'b0;
    rob_ready = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cdb_round_robin();
    test_single_requester();
    test_wrap();
    test_rob_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_writeback_arbiter.md
# fu_writeback_arbiter

Shares the common data bus (CDB) and the single ROB write port between NUM_FU functional-unit output stages (ALU, load/store, branch units). Each channel is arbitrated independently with a round-robin grant, and the winner's payload is registered onto a broadcast bus one cycle later. Grants drive each FU's `cdb_transmit`/`rob_transmit` inputs. An FU's `cdb_transmit_out`/`rob_transmit_out` and payload outputs drive the request side.

## Interface
- NUM_FU, 4, number of requesting FUs (2..8); index 0 is the lowest index.
- ID_W, 4, ROB id width.
- DATA_W, 8, value/flags/wbs width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  squash: no grants issued; output valids clear at the next edge.
- fu_cdb_req  in  NUM_FU  per-FU CDB request.
- fu_cdb_id  in  NUM_FU x ID_W  per-FU CDB tag.
- fu_cdb_val  in  NUM_FU x DATA_W  per-FU CDB value.
- fu_cdb_grant  out  NUM_FU  one-hot-or-zero CDB grant; combinational.
- cdb_valid  out  1  broadcast valid; registered.
- cdb_id  out  ID_W  broadcast tag; registered.
- cdb_val  out  DATA_W  broadcast value; registered.
- fu_rob_req  in  NUM_FU  per-FU ROB write request.
- fu_rob_robid  in  NUM_FU x ID_W  per-FU ROB entry.
- fu_rob_flags  in  NUM_FU x DATA_W  per-FU flags.
- fu_rob_wbs  in  NUM_FU x DATA_W  per-FU writeback select.
- fu_rob_value  in  NUM_FU x DATA_W  per-FU result.
- rob_ready  in  1  ROB can accept a write this cycle.
- fu_rob_grant  out  NUM_FU  one-hot-or-zero ROB grant; combinational.
- rob_valid  out  1  ROB write valid; registered.
- rob_robid  out  ID_W  ROB write entry; registered.
- rob_flags  out  DATA_W  ROB write flags; registered.
- rob_wbs  out  DATA_W  ROB write writeback select; registered.
- rob_value  out  DATA_W  ROB write value; registered.

## Operation
- There are two identical, independent channels (CDB and ROB). Each channel has a pointer register `last`, of width clog2(NUM_FU), holding the index of the most recently granted FU.
- Priority order is last+1, last+2, ..., last, modulo NUM_FU, so wrap from NUM_FU-1 to 0 is required.
- Grant: the first requesting index in priority order gets the grant. A grant is issued only if:
  - flush=0, and
  - for the ROB channel only, rob_ready=1.
  - Otherwise the grant vector is all-zero.
- Handshake:
  - An FU holds its req high, with stable payload, until it samples its grant high at a clock edge.
  - An FU drops req, or presents new data, in the cycle after the grant.
  - The arbiter never issues a grant to a non-requesting FU.
- On a grant edge:
  - `last` takes the winner's index.
  - The output registers take the winner's payload, with valid=1.
- With no grant, valid=0, `last` holds, and the payload registers hold their previous value (don't-care while valid=0).
- Fairness: with requests continuously held, every requester is granted at least once per NUM_FU granted cycles. A single requester is granted every cycle.
- The channels do not interact. One FU may win CDB and ROB in the same cycle, or win one and wait on the other.

## Timing
- Reset (async assert):
  - cdb_valid=0, rob_valid=0.
  - All payload outputs are 0.
  - Both `last`=NUM_FU-1, so FU0 has top priority on the first cycle after reset.
  - Grants are 0 while rst=1.
- Latency: req seen in cycle N with grant → payload on the broadcast bus with valid=1 in cycle N+1, for exactly one cycle per grant.
- Back-to-back: the CDB channel sustains one broadcast per cycle. The ROB channel sustains one write per cycle while rob_ready=1.
- rob_ready low: the ROB grant is 0 that cycle, and rob_valid=0 next cycle. The CDB channel is unaffected.
- flush (synchronous, sampled at the edge):
  - Grants are 0 in the flush cycle.
  - Both valids are 0 in the cycle after.
  - `last` holds.
  - A valid already on the output during the flush cycle is not retracted.
- rst asserted mid-operation: valids clear immediately (asynchronously), and any combinational grant drops in the same cycle.

## Test plan
- Reset, then FU0..FU3 all request the CDB with id=1..4 and val=0x10..0x40 held → grants FU0, FU1, FU2, FU3. CDB output sequence is (1,0x10), (2,0x20), (3,0x30), (4,0x40), one per cycle starting one cycle after the first grant.
- last=3, only FU3 requests the CDB for 3 cycles → FU3 is granted every cycle; cdb_valid=1 for 3 consecutive cycles with FU3's payload.
- last=1, FU0 and FU3 request → FU3 granted first, then FU0 (wrap-around order).
- All FUs request the ROB and rob_ready=0 for 2 cycles, then 1 → no ROB grants and rob_valid=0 during the stall. Grants then resume at FU0 with payload intact, while CDB grants continue throughout.
- flush=1 for one cycle while FU2 requests both channels → no grants that cycle; cdb_valid=rob_valid=0 the next cycle. FU2 is granted on both channels the cycle after flush deasserts.
- rst asserted asynchronously between edges while cdb_valid=1 → cdb_valid and rob_valid go to 0 immediately. After release, FU0 wins a simultaneous FU0/FU1 request.
